gpio_board_io: RTL
==================

# gpio_board_io

Board-side endpoint of the CPU's GPIO port. It drives the CPU's 32-bit `gpio_in` word from synchronized switches and debounced push-buttons, including a KEY0 press counter. It also renders the CPU's `gpio_out` word on LEDs and on an 8-digit time-multiplexed seven-segment display. The block sits at top level between the `cpu` instance and the FPGA pins.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz).
- `SCAN_CYCLES`, default 50000: cycles each display digit stays enabled.
- `clk`  input  1  system clock, the same clock as `cpu`.
- `rst`  input  1  reset; one clock, reset is synchronous and active-high.
- `sw`  input  18  slide switches; asynchronous.
- `key_n`  input  4  push-buttons, active-low; asynchronous.
- `gpio_out`  input  32  word written by the CPU.
- `gpio_in`  output  32  word read by the CPU (registered).
- `ledr`  output  18  red LEDs, active-high (registered).
- `seg_n`  output  7  segments, active-low; bit 0 = a … bit 6 = g (registered).
- `dig_n`  output  8  digit enables, active-low, one-hot; bit 0 = least-significant digit (registered).

## Operation
- Switches: 2-flop synchronizer feeds `gpio_in[17:0]`.
- Keys:
  - Each key passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer counter clears on any cycle where the synced value equals the accepted level.
  - When the synced value differs for `DEBOUNCE_CYCLES` consecutive cycles, the accepted level updates.
  - `gpio_in[21:18]` = accepted pressed state (inverted `key_n`).
  - `gpio_in[23:22]` = 0.
- Press counter:
  - Increments once per accepted release→press transition of KEY0.
  - 8 bits; wraps 255→0.
  - Drives `gpio_in[31:24]`.
- LEDs: `ledr` = `gpio_out[17:0]`, registered.
- Display scan:
  - A digit index 0..7 advances every `SCAN_CYCLES` cycles and wraps 7→0.
  - `dig_n` = ~(1 << index).
  - `seg_n` = decode of that digit's nibble from the display register.
  - `seg_n` and `dig_n` change in the same cycle.
- Hex mode (default): the display register loads `gpio_out` every cycle; digit i shows `gpio_out[4i+3:4i]`.
- Reset values:
  - `gpio_in` = 0, `ledr` = 0, `seg_n` = 7'h7F, `dig_n` = 8'hFF.
  - Debounced levels = released; counters = 0; display register = 0; scan index = 0.
  - First digit is enabled on the cycle after reset is released.

## Timing
- Switch path: a change on `sw` appears on `gpio_in` 3 cycles later.
- Key path:
  - An accepted level appears on `gpio_in` 3 + `DEBOUNCE_CYCLES` cycles after a clean edge.
  - The press count updates in the same cycle as `gpio_in[18]`.
- Glitch rule: a key glitch shorter than `DEBOUNCE_CYCLES` produces no change and no count.
- All four keys pressed in the same cycle are handled independently; only KEY0 counts.
- Hex-mode display reflects `gpio_out` 1 cycle after a change, at the next scanned digit.
- Reset asserted mid-operation returns every register to its reset value on that edge.

## Configuration
- `GPIO_DEC_DISPLAY_EN` defined: the display shows `gpio_out[25:0]` as unsigned decimal on 8 BCD digits.
  - Bits [31:26] are ignored for display.
  - Conversion is a shift-add-3 FSM with states IDLE, SHIFT, DONE:
    - IDLE: if `gpio_out[25:0]` ≠ last converted value, latch the value, load the shifter, and go to SHIFT.
    - SHIFT: 26 cycles; each cycle adds 3 to every BCD digit ≥ 5, then shifts left 1.
    - DONE: copy the BCD result into the display register atomically, then go to IDLE.
  - Latency from `gpio_out` change to display update is 28 cycles.
  - A change during SHIFT does not abort the conversion; IDLE detects it the cycle after DONE and restarts.
  - Last converted value resets to 0 (consistent with display 0).
- Undefined: hex mode; no converter logic is present.

## Structure
- `gpio_board_pkg` contains:
  - `gpio_in` field localparams: SW_LSB=0, KEY_LSB=18, CNT_LSB=24, SW_W=18.
  - `hex_to_seg_n` function (nibble → active-low segments).
  - Converter state enum.
- Sub-module `key_debounce`: synchronizer plus debouncer plus rising-press pulse, parameterized by `DEBOUNCE_CYCLES`; instantiated 4×.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `SCAN_CYCLES`=2.
- Reset → `gpio_in`=0, `ledr`=0, `seg_n`=7'h7F, `dig_n`=8'hFF; after release `dig_n` cycles FE, FD, FB … 7F, FE, with 2 cycles per digit.
- `sw`=18'h2A5A5 → `gpio_in[17:0]`=18'h2A5A5 exactly 3 cycles later; `gpio_out`=32'h0003FFFF → `ledr`=18'h3FFFF.
- Debounce and counting:
  - `key_n[0]` low for 3 cycles, then high → `gpio_in[18]` stays 0 and count stays 0.
  - Hold low for 10 cycles → `gpio_in[18]`=1 and `gpio_in[31:24]`=1.
  - 256 clean presses → count wraps to 0.
- Hex mode, `gpio_out`=32'h89ABCDE7:
  - When `dig_n`=8'hFE, `seg_n`=7'b1111000 (digit "7").
  - When `dig_n`=8'h7F, `seg_n`=7'b0000000 (digit "8").
- `GPIO_DEC_DISPLAY_EN`:
  - `gpio_out`=12345678 → the display register holds BCD 32'h12345678 28 cycles later.
  - Switching to 99 at SHIFT cycle 10 → 12345678 is shown first, then 32'h00000099.
- `rst` pulsed during SHIFT → display register = 0 and FSM = IDLE; the unchanged `gpio_out` triggers a fresh conversion after release.

Source files
------------

// File: rtl/gpio_board_pkg.sv
// Shared definitions for the board-side GPIO endpoint: gpio_in field positions,
// seven-segment decode, and the decimal converter's state type and BCD helper.
package gpio_board_pkg;

  localparam int SW_LSB  = 0;
  localparam int KEY_LSB = 18;
  localparam int CNT_LSB = 24;
  localparam int SW_W    = 18;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Double-dabble correction step: every BCD digit of 5 or more gets 3 added.
  function automatic logic [31:0] bcd_add3(input logic [31:0] bcd);
    logic [31:0] res;
    res = bcd;
    for (int d = 0; d < 8; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, stable-count debouncer and a one-cycle
// pulse on each accepted release-to-press transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync != level) && (cnt == CNT_LAST);
  assign press  = accept && sync;

  // Synced value is kept in pressed-high sense so level needs no later inversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= ~key_n;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_board_io.sv
// Board-side GPIO endpoint: switches/keys into gpio_in, gpio_out onto LEDs and a
// scanned 8-digit display. Define GPIO_DEC_DISPLAY_EN for decimal display mode.
module gpio_board_io
  import gpio_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_CYCLES     = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] sw,
  input  logic [3:0]  key_n,
  input  logic [31:0] gpio_out,
  output logic [31:0] gpio_in,
  output logic [17:0] ledr,
  output logic [6:0]  seg_n,
  output logic [7:0]  dig_n
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic [17:0]       sw_meta;
  logic [17:0]       sw_sync;
  logic [3:0]        key_level;
  logic [3:0]        key_press;
  logic [2:0]        unused_press;
  logic [7:0]        press_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        scan_idx;
  logic [31:0]       disp_reg;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n[i]),
      .level (key_level[i]),
      .press (key_press[i])
    );
  end

  // Only KEY0 presses are counted.
  assign unused_press = key_press[3:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      press_cnt <= '0;
      gpio_in   <= '0;
      ledr      <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (key_press[0]) press_cnt <= press_cnt + 8'd1;
      gpio_in[SW_LSB +: SW_W]    <= sw_sync;
      gpio_in[KEY_LSB +: 4]      <= key_level;
      gpio_in[KEY_LSB + 4 +: 2]  <= 2'b00;
      gpio_in[CNT_LSB +: 8]      <= press_cnt;
      ledr <= gpio_out[17:0];
    end
  end

  // seg_n and dig_n come from the same index so they always switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg_n    <= 7'h7F;
      dig_n    <= 8'hFF;
    end else begin
      dig_n <= ~(8'b1 << scan_idx);
      seg_n <= hex_to_seg_n(disp_reg[{scan_idx, 2'b00} +: 4]);
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

`ifdef GPIO_DEC_DISPLAY_EN
  conv_state_t conv_state;
  conv_state_t conv_next;
  logic [25:0] last_val;
  logic [25:0] bin_sh;
  logic [31:0] bcd_sh;
  logic [31:0] bcd_adj;
  logic [4:0]  bit_cnt;
  logic [5:0]  unused_gpio_hi;

  assign unused_gpio_hi = gpio_out[31:26];
  assign bcd_adj        = bcd_add3(bcd_sh);

  always_ff @(posedge clk) begin
    if (rst) conv_state <= IDLE;
    else     conv_state <= conv_next;
  end

  always_comb begin
    conv_next = conv_state;
    case (conv_state)
      IDLE:    if (gpio_out[25:0] != last_val) conv_next = SHIFT;
      SHIFT:   if (bit_cnt == 5'd25) conv_next = DONE;
      DONE:    conv_next = IDLE;
      default: conv_next = IDLE;
    endcase
  end

  // A change arriving mid-conversion is picked up by IDLE after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_val <= '0;
      bin_sh   <= '0;
      bcd_sh   <= '0;
      bit_cnt  <= '0;
      disp_reg <= '0;
    end else begin
      case (conv_state)
        IDLE: begin
          if (gpio_out[25:0] != last_val) begin
            last_val <= gpio_out[25:0];
            bin_sh   <= gpio_out[25:0];
            bcd_sh   <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          bcd_sh  <= {bcd_adj[30:0], bin_sh[25]};
          bin_sh  <= {bin_sh[24:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
        end
        DONE:    disp_reg <= bcd_sh;
        default: ;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) disp_reg <= '0;
    else     disp_reg <= gpio_out;
  end
`endif

endmodule
